dmem_responder: RTL and testbench

- Data-memory responder that sits at the far end of the core's D_MEM interface.
- Accepts word and byte loads and stores from the core pipeline, returns load data with a fixed 1-cycle latency, and flags misaligned accesses.
- A secondary debug/loader port with a req/ready/rvalid handshake gives testbench and boot-loader access; it is granted only in cycles where the core is idle.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 43 ++++
 rtl/dmem_responder_align.sv | 43 ++++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// dmem_responder shared types and helpers.
// Access modes, debug FSM states, lane count.
package dmem_pkg;

  typedef enum logic {
    MODE_WORD = 1'b0,
    MODE_BYTE = 1'b1
  } mem_mode_e;

  typedef enum logic {
    DBG_IDLE,
    DBG_RESP
  } dbg_state_e;

  localparam int BYTE_LANES = 4;

  function automatic logic [31:0] sext8(
    input logic [7:0] b
  );
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core D_MEM bus plus debug/loader port.
// master = core/loader side, slave = responder.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  import dmem_pkg::*;

  logic                  memRead;
  logic                  memWrite;
  mem_mode_e             memMode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  misaligned;

  logic                  dbg_req;
  logic                  dbg_we;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [WORD_WIDTH-1:0] dbg_wdata;
  logic                  dbg_ready;
  logic                  dbg_rvalid;
  logic [WORD_WIDTH-1:0] dbg_rdata;

  modport master (
    output memRead, memWrite, memMode,
    output addr, wdata,
    input  rdata, misaligned,
    output dbg_req, dbg_we,
    output dbg_addr, dbg_wdata,
    input  dbg_ready, dbg_rvalid, dbg_rdata
  );

  modport slave (
    input  memRead, memWrite, memMode,
    input  addr, wdata,
    output rdata, misaligned,
    input  dbg_req, dbg_we,
    input  dbg_addr, dbg_wdata,
    output dbg_ready, dbg_rvalid, dbg_rdata
  );

endinterface

// File: rtl/dmem_responder_align.sv
// Lane steering for core accesses.
// Byte enables, store data, LB extension.
module dmem_align
  import dmem_pkg::*;
(
  input  mem_mode_e   mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [7:0] lane_byte;

  assign lane_byte = raw[{addr_lo, 3'b000} +: 8];

  // steer data and enables by access size
  always_comb begin
    be         = '0;
    wdata_sh   = wdata;
    rdata      = '0;
    misaligned = 1'b0;
    unique case (mode)
      MODE_WORD: begin
        misaligned = |addr_lo;
        if (!misaligned) begin
          be    = 4'hF;
          rdata = raw;
        end
      end
      MODE_BYTE: begin
        be       = 4'b0001 << addr_lo;
        wdata_sh = {BYTE_LANES{wdata[7:0]}};
        rdata    = sext8(lane_byte);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: core port wins,
// debug port served in idle cycles.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_WIDTH  = 32,
  parameter int WORD_WIDTH  = 32
) (
  input logic         clk,
  input logic         rst_n,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] core_idx;
  logic [IDX_W-1:0] dbg_idx;
  logic             core_wr;
  logic             core_rd;
  logic             dbg_grant;
  logic             dbg_wr;
  logic             dbg_rd;

  logic [3:0]            al_be;
  logic [WORD_WIDTH-1:0] al_wdata;
  logic [WORD_WIDTH-1:0] al_rdata;
  logic                  al_mis;

  logic [WORD_WIDTH-1:0] rdata_q;
  logic [WORD_WIDTH-1:0] dbg_rdata_q;
  logic                  mis_q;
  dbg_state_e            st_q;
  dbg_state_e            st_d;

  logic unused_bits;

  assign core_idx = bus.addr[IDX_W+1:2];
  assign dbg_idx  = bus.dbg_addr[IDX_W+1:2];

  assign unused_bits = ^{
    bus.addr[ADDR_WIDTH-1:IDX_W+2],
    bus.dbg_addr[ADDR_WIDTH-1:IDX_W+2],
    bus.dbg_addr[1:0]
  };

  assign core_wr = bus.memWrite & rst_n;
  assign core_rd = bus.memRead & ~bus.memWrite;

  assign dbg_grant = bus.dbg_req & ~bus.memRead
                   & ~bus.memWrite & rst_n;
  assign dbg_wr    = dbg_grant & bus.dbg_we;
  assign dbg_rd    = dbg_grant & ~bus.dbg_we;

  dmem_align u_align (
    .mode       (bus.memMode),
    .addr_lo    (bus.addr[1:0]),
    .wdata      (bus.wdata),
    .raw        (mem[core_idx]),
    .be         (al_be),
    .wdata_sh   (al_wdata),
    .rdata      (al_rdata),
    .misaligned (al_mis)
  );

  // array write: core store lanes, else debug word
  always_ff @(posedge clk) begin
    if (core_wr) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (al_be[i]) begin
          mem[core_idx][8*i +: 8] <= al_wdata[8*i +: 8];
        end
      end
    end else if (dbg_wr) begin
      mem[dbg_idx] <= bus.dbg_wdata;
    end
  end

  // registered read data and misalign pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q     <= '0;
      dbg_rdata_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      mis_q <= (bus.memRead | bus.memWrite) & al_mis;
      if (core_rd) rdata_q <= al_rdata;
      if (dbg_rd) dbg_rdata_q <= mem[dbg_idx];
    end
  end

  // debug FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) st_q <= DBG_IDLE;
    else        st_q <= st_d;
  end

  // debug FSM next state: RESP follows each read grant
  always_comb begin
    st_d = DBG_IDLE;
    unique case (st_q)
      DBG_IDLE: if (dbg_rd) st_d = DBG_RESP;
      DBG_RESP: if (dbg_rd) st_d = DBG_RESP;
      default:  st_d = DBG_IDLE;
    endcase
  end

  assign bus.rdata      = rdata_q;
  assign bus.misaligned = mis_q;
  assign bus.dbg_ready  = dbg_grant;
  assign bus.dbg_rvalid = (st_q == DBG_RESP);
  assign bus.dbg_rdata  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Byte-array reference model, directed + random.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int MEMB = 4096;

  logic clk;
  logic rst_n;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  logic [7:0]  mb [MEMB];
  logic [31:0] exp_rd;
  logic [31:0] exp_drd;
  logic        exp_mis;
  logic        exp_rv;

  logic        r_r, r_w, r_m, r_dq, r_dw;
  logic [31:0] r_a, r_d, r_da, r_dd;
  int          op;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mload(
    input logic        m,
    input logic [31:0] a
  );
    int b;
    b = int'(a[11:0]);
    if (m) return {{24{mb[b][7]}}, mb[b]};
    if (a[1:0] != 2'b00) return 32'h0;
    return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
  endfunction

  task automatic mstore(
    input logic        m,
    input logic [31:0] a,
    input logic [31:0] d
  );
    int b;
    b = int'(a[11:0]);
    if (m) begin
      mb[b] = d[7:0];
    end else if (a[1:0] == 2'b00) begin
      for (int i = 0; i < 4; i++) mb[b+i] = d[8*i +: 8];
    end
  endtask

  // one clock: drive at negedge, check after edge
  task automatic cyc(
    input logic        rst,
    input logic        r,
    input logic        w,
    input logic        m,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic        dq,
    input logic        dw,
    input logic [31:0] da,
    input logic [31:0] dd
  );
    logic rdy;
    rst_n         = rst;
    bus.memRead   = r;
    bus.memWrite  = w;
    bus.memMode   = mem_mode_e'(m);
    bus.addr      = a;
    bus.wdata     = d;
    bus.dbg_req   = dq;
    bus.dbg_we    = dw;
    bus.dbg_addr  = da;
    bus.dbg_wdata = dd;
    #1;
    rdy = rst & dq & ~r & ~w;
    check("dbg_ready", {31'b0, bus.dbg_ready},
          {31'b0, rdy});
    if (!rst) begin
      exp_rd  = '0;
      exp_drd = '0;
      exp_mis = 1'b0;
      exp_rv  = 1'b0;
    end else begin
      exp_mis = (r | w) & ~m & (a[1:0] != 2'b00);
      if (w) mstore(m, a, d);
      else if (r) exp_rd = mload(m, a);
      exp_rv = rdy & ~dw;
      if (rdy) begin
        if (dw) mstore(1'b0, {da[31:2], 2'b00}, dd);
        else exp_drd = mload(1'b0, {da[31:2], 2'b00});
      end
    end
    @(negedge clk);
    check("rdata", bus.rdata, exp_rd);
    check("misaligned", {31'b0, bus.misaligned},
          {31'b0, exp_mis});
    check("dbg_rvalid", {31'b0, bus.dbg_rvalid},
          {31'b0, exp_rv});
    check("dbg_rdata", bus.dbg_rdata, exp_drd);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_rd = '0;
    exp_drd = '0;
    exp_mis = 1'b0;
    exp_rv  = 1'b0;
    rst_n = 1'b0;
    bus.memRead = 1'b0;
    bus.memWrite = 1'b0;
    bus.memMode = MODE_WORD;
    bus.addr = '0;
    bus.wdata = '0;
    bus.dbg_req = 1'b0;
    bus.dbg_we = 1'b0;
    bus.dbg_addr = '0;
    bus.dbg_wdata = '0;
    @(negedge clk);

    // reset with requests pending
    cyc(0, 1, 0, 0, 32'h10, 0, 1, 0, 32'h10, 0);
    cyc(0, 1, 0, 0, 32'h10, 0, 1, 0, 32'h10, 0);

    // preload whole array over debug port
    for (int i = 0; i < 1024; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 1, 1,
          32'(i * 4), $urandom);
    end

    // word store then load
    cyc(1, 0, 1, 0, 32'h10, 32'hDEADBEEF,
        0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0);
    check("word_load", bus.rdata, 32'hDEADBEEF);

    // byte lanes
    cyc(1, 0, 1, 0, 32'h20, 32'h11223344,
        0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h22, 32'h000000AA,
        0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h20, 0, 0, 0, 0, 0);
    check("lane_word", bus.rdata, 32'h11AA3344);
    cyc(1, 1, 0, 1, 32'h22, 0, 0, 0, 0, 0);
    check("lb_neg", bus.rdata, 32'hFFFFFFAA);
    cyc(1, 1, 0, 1, 32'h23, 0, 0, 0, 0, 0);
    check("lb_pos", bus.rdata, 32'h00000011);

    // misaligned store and load
    cyc(1, 0, 1, 0, 32'h31, 32'h12345678,
        0, 0, 0, 0);
    check("mis_st", {31'b0, bus.misaligned}, 32'h1);
    cyc(1, 1, 0, 0, 32'h30, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h32, 0, 0, 0, 0, 0);
    check("mis_ld_data", bus.rdata, 32'h0);
    check("mis_ld_flag", {31'b0, bus.misaligned},
          32'h1);
    idle();
    check("mis_drop", {31'b0, bus.misaligned},
          32'h0);

    // debug read starved by three core loads
    cyc(1, 1, 0, 0, 32'h20, 0, 1, 0, 32'h10, 0);
    cyc(1, 1, 0, 1, 32'h21, 0, 1, 0, 32'h10, 0);
    cyc(1, 1, 0, 0, 32'h10, 0, 1, 0, 32'h10, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0);
    check("arb_rvalid", {31'b0, bus.dbg_rvalid},
          32'h1);
    check("arb_rdata", bus.dbg_rdata, 32'hDEADBEEF);
    idle();

    // address wrap, then load+store together
    cyc(1, 0, 1, 0, 32'h1000, 32'h55,
        0, 0, 0, 0);
    cyc(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0);
    check("wrap", bus.rdata, 32'h55);
    cyc(1, 1, 1, 0, 32'h40, 32'hCAFEF00D,
        0, 0, 0, 0);
    check("rw_hold", bus.rdata, 32'h55);
    cyc(1, 1, 0, 0, 32'h40, 0, 0, 0, 0, 0);
    check("rw_store", bus.rdata, 32'hCAFEF00D);

    // back-to-back debug reads, then reset
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h21, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'h13, 0);
    check("b2b_rdata", bus.dbg_rdata, 32'hDEADBEEF);
    cyc(0, 1, 0, 0, 32'h10, 0, 1, 0, 32'h10, 0);
    check("rst_rvalid", {31'b0, bus.dbg_rvalid},
          32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    idle();
    cyc(1, 1, 0, 0, 32'h10, 0, 0, 0, 0, 0);
    check("post_rst", bus.rdata, 32'hDEADBEEF);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      op   = int'($urandom_range(0, 9));
      r_r  = (op < 4) || (op == 8);
      r_w  = ((op >= 4) && (op < 7)) || (op == 8);
      r_m  = 1'($urandom_range(0, 1));
      r_a  = $urandom & 32'hFFFF_F0FF;
      r_d  = $urandom;
      r_dq = ($urandom_range(0, 2) == 0);
      r_dw = 1'($urandom_range(0, 1));
      r_da = $urandom & 32'hFFFF_F0FF;
      r_dd = $urandom;
      cyc(1, r_r, r_w, r_m, r_a, r_d,
          r_dq, r_dw, r_da, r_dd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
